// File: rtl/datapath_pkg.sv
// datapath_pkg: shared types and defaults for bus_datapath.
// Holds the ALU op codes, the ALU FSM states and the default sizes.
package datapath_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;

  typedef enum logic [4:0] {
    OP_ZERO = 5'd0,
    OP_OR   = 5'd1,
    OP_AND  = 5'd2,
    OP_XOR  = 5'd3,
    OP_SLL  = 5'd4,
    OP_SRL  = 5'd5,
    OP_SRA  = 5'd6,
    OP_LTU  = 5'd7,
    OP_LEU  = 5'd8,
    OP_EQ   = 5'd9,
    OP_GTU  = 5'd10,
    OP_GEU  = 5'd11,
    OP_ADD  = 5'd12,
    OP_SUB  = 5'd13,
    OP_MUL  = 5'd14
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_seq.sv
// alu_seq: operand latches, IDLE/EXEC/DONE FSM, registered result and flags.
// Ports: clk, rst_n (async, active-low), func_sel, store_1/2, start, bus_in;
// busy, done, result, flag_zero/carry/illegal. BUS_DATAPATH_MUL_EN adds the
// iterative shift-add multiplier for op 14.
module alu_seq
  import datapath_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      func_sel,
  input  logic            store_1,
  input  logic            store_2,
  input  logic            start,
  input  logic [XLEN-1:0] bus_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            flag_zero,
  output logic            flag_carry,
  output logic            flag_illegal
);

  localparam int SHW = $clog2(XLEN);

  alu_state_e      state_q, state_d;
  logic [4:0]      op_q, op_d;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            fz_q, fz_d, fc_q, fc_d, fi_q, fi_d;
  logic            busy_q, busy_d, done_q, done_d;

  logic [XLEN-1:0] alu_y, fin_y;
  logic            alu_c, alu_ill, fin, fin_c, fin_i;
  logic [XLEN:0]   sum, dif;
  logic [SHW-1:0]  shamt;

`ifdef BUS_DATAPATH_MUL_EN
  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);
  logic [XLEN-1:0] acc_q, acc_d, mcd_q, mcd_d, mpl_q, mpl_d, acc_nx;
  logic [SHW-1:0]  cnt_q, cnt_d;
`endif

  assign shamt = op2_q[SHW-1:0];

  // dif[XLEN] is the borrow of the unsigned subtraction
  always_comb begin
    sum     = {1'b0, op1_q} + {1'b0, op2_q};
    dif     = {1'b0, op1_q} - {1'b0, op2_q};
    alu_y   = '0;
    alu_c   = 1'b0;
    alu_ill = 1'b0;
    case (op_q)
      OP_ZERO: alu_y = '0;
      OP_OR:   alu_y = op1_q | op2_q;
      OP_AND:  alu_y = op1_q & op2_q;
      OP_XOR:  alu_y = op1_q ^ op2_q;
      OP_SLL:  alu_y = op1_q << shamt;
      OP_SRL:  alu_y = op1_q >> shamt;
      OP_SRA:  alu_y = $unsigned($signed(op1_q) >>> shamt);
      OP_LTU:  alu_y = XLEN'(op1_q <  op2_q);
      OP_LEU:  alu_y = XLEN'(op1_q <= op2_q);
      OP_EQ:   alu_y = XLEN'(op1_q == op2_q);
      OP_GTU:  alu_y = XLEN'(op1_q >  op2_q);
      OP_GEU:  alu_y = XLEN'(op1_q >= op2_q);
      OP_ADD: begin
        alu_y = sum[XLEN-1:0];
        alu_c = sum[XLEN];
      end
      OP_SUB: begin
        alu_y = dif[XLEN-1:0];
        alu_c = dif[XLEN];
      end
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    fz_d    = fz_q;
    fc_d    = fc_q;
    fi_d    = fi_q;
    fin     = 1'b0;
    fin_y   = alu_y;
    fin_c   = alu_c;
    fin_i   = alu_ill;
`ifdef BUS_DATAPATH_MUL_EN
    acc_d  = acc_q;
    mcd_d  = mcd_q;
    mpl_d  = mpl_q;
    cnt_d  = cnt_q;
    acc_nx = acc_q + (mpl_q[0] ? mcd_q : '0);
`endif
    if (state_q != EXEC) begin
      if (store_1) op1_d = bus_in;
      if (store_2) op2_d = bus_in;
    end
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = EXEC;
          op_d    = func_sel;
`ifdef BUS_DATAPATH_MUL_EN
          // operands stored in the start cycle are already visible here
          acc_d = '0;
          mcd_d = op1_d;
          mpl_d = op2_d;
          cnt_d = '0;
`endif
        end
      end
      EXEC: begin
`ifdef BUS_DATAPATH_MUL_EN
        if (op_q == OP_MUL) begin
          acc_d = acc_nx;
          mcd_d = mcd_q << 1;
          mpl_d = mpl_q >> 1;
          cnt_d = cnt_q + SHW'(1);
          fin   = (cnt_q == CNT_LAST);
          fin_y = acc_nx;
          fin_c = 1'b0;
          fin_i = 1'b0;
        end else begin
          fin = 1'b1;
        end
`else
        fin = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d = DONE;
      res_d   = fin_y;
      fz_d    = (fin_y == '0);
      fc_d    = fin_c;
      fi_d    = fin_i;
    end
    busy_d = (state_d == EXEC);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      fz_q    <= 1'b0;
      fc_q    <= 1'b0;
      fi_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BUS_DATAPATH_MUL_EN
      acc_q   <= '0;
      mcd_q   <= '0;
      mpl_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      fz_q    <= fz_d;
      fc_q    <= fc_d;
      fi_q    <= fi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BUS_DATAPATH_MUL_EN
      acc_q   <= acc_d;
      mcd_q   <= mcd_d;
      mpl_q   <= mpl_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = res_q;
  assign flag_zero    = fz_q;
  assign flag_carry   = fc_q;
  assign flag_illegal = fi_q;

endmodule

// File: rtl/bus_datapath.sv
// bus_datapath: register file and single shared bus around alu_seq.
// Ports: clk, reset (async, active-low), ALU/register/imm controls in;
// bus_out/valid/conflict, ALU status, result and flags out.
// BUS_DATAPATH_MUL_EN enables the iterative multiplier (op 14).
module bus_datapath
  import datapath_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREGS  = DEF_NREGS,
  parameter int RIDX_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        alu_function_sel,
  input  logic              alu_store_1,
  input  logic              alu_store_2,
  input  logic              alu_start,
  input  logic              alu_broadcast,
  input  logic [RIDX_W-1:0] register_index,
  input  logic              register_read_enable,
  input  logic              register_write_enable,
  input  logic [XLEN-1:0]   imm,
  input  logic              imm_EN,
  output logic [XLEN-1:0]   bus_out,
  output logic              bus_valid,
  output logic              bus_conflict,
  output logic              alu_busy,
  output logic              alu_done,
  output logic [XLEN-1:0]   alu_result,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              flag_illegal
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [XLEN-1:0] rd_val;
  logic [1:0]      n_drv;

  // r0 is never written, so it stays at its reset value of 0
  assign rd_val = regs_q[register_index];

  always_comb begin
    n_drv = 2'(alu_broadcast) + 2'(register_read_enable) + 2'(imm_EN);
    bus_out = '0;
    if (alu_broadcast)             bus_out = alu_result;
    else if (register_read_enable) bus_out = rd_val;
    else if (imm_EN)               bus_out = imm;
    bus_valid    = (n_drv != 2'd0);
    bus_conflict = (n_drv >= 2'd2);
  end

  always_comb begin
    regs_d = regs_q;
    if (register_write_enable && (register_index != '0))
      regs_d[register_index] = bus_out;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  alu_seq #(
    .XLEN(XLEN)
  ) u_alu (
    .clk         (clk),
    .rst_n       (reset),
    .func_sel    (alu_function_sel),
    .store_1     (alu_store_1),
    .store_2     (alu_store_2),
    .start       (alu_start),
    .bus_in      (bus_out),
    .busy        (alu_busy),
    .done        (alu_done),
    .result      (alu_result),
    .flag_zero   (flag_zero),
    .flag_carry  (flag_carry),
    .flag_illegal(flag_illegal)
  );

endmodule

// File: tb/tb_bus_datapath.sv
// tb_bus_datapath: directed and random checks of bus_datapath
// against a behavioural model of the ALU and register file.
module tb_bus_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  alu_function_sel;
  logic        alu_store_1, alu_store_2, alu_start, alu_broadcast;
  logic [4:0]  register_index;
  logic        register_read_enable, register_write_enable;
  logic [31:0] imm;
  logic        imm_EN;
  logic [31:0] bus_out, alu_result;
  logic        bus_valid, bus_conflict, alu_busy, alu_done;
  logic        flag_zero, flag_carry, flag_illegal;

  int checks = 0;
  int errors = 0;
  logic [31:0] rmodel [32];
  logic [31:0] last_y;

`ifdef BUS_DATAPATH_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  bus_datapath dut (
    .clk                  (clk),
    .reset                (reset),
    .alu_function_sel     (alu_function_sel),
    .alu_store_1          (alu_store_1),
    .alu_store_2          (alu_store_2),
    .alu_start            (alu_start),
    .alu_broadcast        (alu_broadcast),
    .register_index       (register_index),
    .register_read_enable (register_read_enable),
    .register_write_enable(register_write_enable),
    .imm                  (imm),
    .imm_EN               (imm_EN),
    .bus_out              (bus_out),
    .bus_valid            (bus_valid),
    .bus_conflict         (bus_conflict),
    .alu_busy             (alu_busy),
    .alu_done             (alu_done),
    .alu_result           (alu_result),
    .flag_zero            (flag_zero),
    .flag_carry           (flag_carry),
    .flag_illegal         (flag_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    alu_function_sel      = '0;
    alu_store_1           = 1'b0;
    alu_store_2           = 1'b0;
    alu_start             = 1'b0;
    alu_broadcast         = 1'b0;
    register_index        = '0;
    register_read_enable  = 1'b0;
    register_write_enable = 1'b0;
    imm                   = '0;
    imm_EN                = 1'b0;
  endtask

  task automatic ref_alu(input int op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] y,
                         output logic c, output logic il);
    int sh;
    longint unsigned wide;
    sh = int'(b % 32);
    y  = '0;
    c  = 1'b0;
    il = 1'b0;
    case (op)
      0:  y = '0;
      1:  y = a | b;
      2:  y = a & b;
      3:  y = a ^ b;
      4:  y = a << sh;
      5:  y = a >> sh;
      6:  y = $signed(a) >>> sh;
      7:  y = {31'd0, a < b};
      8:  y = {31'd0, a <= b};
      9:  y = {31'd0, a == b};
      10: y = {31'd0, a > b};
      11: y = {31'd0, a >= b};
      12: begin
        wide = longint'(a) + longint'(b);
        y = a + b;
        c = (wide > 64'hFFFF_FFFF);
      end
      13: begin
        y = a - b;
        c = (a < b);
      end
      14: begin
        if (MUL_ON) y = a * b;
        else        il = 1'b1;
      end
      default: il = 1'b1;
    endcase
  endtask

  task automatic load(input int which, input logic [31:0] v);
    imm    = v;
    imm_EN = 1'b1;
    if (which == 1) alu_store_1 = 1'b1;
    else            alu_store_2 = 1'b1;
    tick();
    imm_EN      = 1'b0;
    alu_store_1 = 1'b0;
    alu_store_2 = 1'b0;
  endtask

  task automatic wr_reg(input int idx, input logic [31:0] v);
    imm                   = v;
    imm_EN                = 1'b1;
    register_index        = idx[4:0];
    register_write_enable = 1'b1;
    tick();
    imm_EN                = 1'b0;
    register_write_enable = 1'b0;
    if (idx != 0) rmodel[idx] = v;
  endtask

  task automatic rd_chk(input int idx, input string tag);
    register_index       = idx[4:0];
    register_read_enable = 1'b1;
    #1;
    chk(tag, bus_out, rmodel[idx]);
    register_read_enable = 1'b0;
  endtask

  task automatic run_op(input int op, input logic [31:0] a,
                        input logic [31:0] b, input bit do_load);
    logic [31:0] ey;
    logic ec, ei;
    int lat, exp_lat;
    if (do_load) begin
      load(1, a);
      load(2, b);
    end
    ref_alu(op, a, b, ey, ec, ei);
    exp_lat = (op == 14 && MUL_ON) ? 32 : 1;
    alu_function_sel = op[4:0];
    alu_start = 1'b1;
    tick();
    alu_start = 1'b0;
    alu_function_sel = 5'($urandom);
    chk($sformatf("busy_op%0d", op), {31'd0, alu_busy}, 32'd1);
    lat = 0;
    while (!alu_done && lat < 100) begin
      tick();
      lat++;
    end
    chk($sformatf("lat_op%0d", op), lat, exp_lat);
    chk($sformatf("res_op%0d", op), alu_result, ey);
    chk($sformatf("flags_op%0d", op),
        {29'd0, flag_zero, flag_carry, flag_illegal},
        {29'd0, ey == 0, ec, ei});
    chk($sformatf("busy_done_op%0d", op), {31'd0, alu_busy}, 32'd0);
    last_y = ey;
    tick();
    chk($sformatf("done_pulse_op%0d", op), {31'd0, alu_done}, 32'd0);
  endtask

  initial begin
    logic [31:0] ey, prev;
    logic ec, ei;
    int lat;
    for (int i = 0; i < 32; i++) rmodel[i] = '0;
    last_y = '0;
    quiet();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_bus", bus_out, 32'd0);
    chk("rst_stat", {26'd0, bus_valid, bus_conflict, alu_busy, alu_done,
                     flag_zero, flag_carry}, 32'd0);
    chk("rst_res", {alu_result[30:0], flag_illegal}, 32'd0);

    // ADD with carry wrapping to zero
    run_op(12, 32'hFFFF_FFFF, 32'd1, 1'b1);
    // arithmetic right shift
    run_op(6, 32'h8000_0000, 32'd4, 1'b1);

    // r0 stays zero
    wr_reg(0, 32'h1234_5678);
    rd_chk(0, "r0_read");
    wr_reg(5, 32'hA5A5_0F0F);
    tick();
    rd_chk(5, "r5_read");

    // contention: register beats immediate
    register_index       = 5'd5;
    register_read_enable = 1'b1;
    imm                  = 32'h1111_1111;
    imm_EN               = 1'b1;
    #1;
    chk("conflict", {30'd0, bus_conflict, bus_valid}, 32'd3);
    chk("conflict_bus", bus_out, 32'hA5A5_0F0F);
    alu_broadcast = 1'b1;
    #1;
    chk("bcast_prio", bus_out, last_y);
    quiet();
    #1;
    chk("idle_bus", bus_out, 32'd0);
    chk("idle_flags", {30'd0, bus_valid, bus_conflict}, 32'd0);

    // same-index read and write returns the old value
    wr_reg(9, 32'hDEAD_BEEF);
    register_index        = 5'd9;
    register_read_enable  = 1'b1;
    register_write_enable = 1'b1;
    imm                   = 32'h0000_1234;
    imm_EN                = 1'b1;
    #1;
    chk("rw_same_old", bus_out, 32'hDEAD_BEEF);
    tick();
    quiet();
    rd_chk(9, "rw_same_after");

    // MUL with stores, broadcast and start ignored during EXEC
    load(1, 32'd7);
    load(2, 32'd6);
    prev = last_y;
    ref_alu(14, 32'd7, 32'd6, ey, ec, ei);
    alu_function_sel = 5'd14;
    alu_start = 1'b1;
    tick();
    alu_start = 1'b0;
    lat = 0;
    while (alu_busy && lat < 100) begin
      imm         = 32'd99;
      imm_EN      = 1'b1;
      alu_store_1 = 1'b1;
      alu_store_2 = 1'b1;
      if (lat == 0) begin
        alu_broadcast = 1'b1;
        if (MUL_ON) begin
          alu_start        = 1'b1;
          alu_function_sel = 5'd12;
        end
        #1;
        chk("bcast_exec", bus_out, prev);
      end
      tick();
      alu_broadcast = 1'b0;
      alu_start     = 1'b0;
      lat++;
    end
    quiet();
    chk("mul_lat", lat, MUL_ON ? 32 : 1);
    chk("mul_res", alu_result, ey);
    chk("mul_ill", {31'd0, flag_illegal}, {31'd0, ei});
    chk("mul_done", {31'd0, alu_done}, 32'd1);
    tick();
    chk("mul_idle", {30'd0, alu_busy, alu_done}, 32'd0);
    run_op(1, 32'd7, 32'd6, 1'b0);

    // back-to-back start in the DONE cycle
    load(1, 32'd10);
    load(2, 32'd3);
    alu_function_sel = 5'd12;
    alu_start = 1'b1;
    tick();
    alu_start = 1'b0;
    tick();
    chk("b2b_done1", {31'd0, alu_done}, 32'd1);
    chk("b2b_res1", alu_result, 32'd13);
    alu_function_sel = 5'd13;
    alu_start = 1'b1;
    tick();
    alu_start = 1'b0;
    chk("b2b_busy", {30'd0, alu_busy, alu_done}, 32'd2);
    tick();
    chk("b2b_done2", {31'd0, alu_done}, 32'd1);
    chk("b2b_res2", alu_result, 32'd7);
    chk("b2b_carry", {31'd0, flag_carry}, 32'd0);
    tick();

    // randomized ops and register round trips
    for (int n = 0; n < 40; n++) begin
      int op, idx;
      logic [31:0] a, b;
      op = $urandom_range(0, 31);
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
      run_op(op, a, b, 1'b1);
      idx = $urandom_range(0, 31);
      wr_reg(idx, $urandom);
      rd_chk(idx, "rand_reg");
    end

    // reset in the middle of an operation
    load(1, 32'd3);
    load(2, 32'd5);
    alu_function_sel = 5'd14;
    alu_start = 1'b1;
    tick();
    alu_start = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_stat", {27'd0, alu_busy, alu_done, flag_zero, flag_carry,
                         flag_illegal}, 32'd0);
    chk("mid_rst_res", alu_result, 32'd0);
    for (int i = 0; i < 32; i++) rmodel[i] = '0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_done", {30'd0, alu_busy, alu_done}, 32'd0);
    end
    rd_chk(5, "rst_reg5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
